// File: rtl/movement_control.sv
// Sprite movement sequencer: turns direction requests into CLEAR / move / DRAW datapath commands once per tick.
// Optional MOVE_AUTOREPEAT_EN: held direction moves every tick; otherwise one move per press.
module movement_control #(
  parameter int TICK_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       enable,
  output logic [3:0] control,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_PREHOLD = 4'b0100,
    ST_HOLD    = 4'b0000,
    ST_CLEAR   = 4'b0001,
    ST_LEFT    = 4'b0011,
    ST_RIGHT   = 4'b0010,
    ST_DOWN    = 4'b0110,
    ST_UP      = 4'b0111,
    ST_DRAW    = 4'b0101
  } state_t;

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t        state, next_state;
  logic [CW-1:0] tick_cnt;
  logic          tick_wrap, tick_pending;
  logic          lat_l, lat_r, lat_u, lat_d;
  logic          first_cyc, boot;
  logic          arm_ok, go;
  logic          x_any, y_any;
  state_t        x_state, y_state;

  assign control   = state;
  assign tick_wrap = (tick_cnt == CW'(TICK_CYCLES - 1));

`ifdef MOVE_AUTOREPEAT_EN
  assign arm_ok = 1'b1;
`else
  logic arm;
  assign arm_ok = arm;

  // Re-arm only after a HOLD cycle with every direction released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm <= 1'b1;
    end else if (go) begin
      arm <= 1'b0;
    end else if (state == ST_HOLD && !(left || right || up || down)) begin
      arm <= 1'b1;
    end
  end
`endif

  always_comb begin
    go      = (state == ST_HOLD) && tick_pending && arm_ok &&
              ((left ^ right) || (up ^ down));
    x_any   = lat_l ^ lat_r;
    y_any   = lat_u ^ lat_d;
    x_state = lat_r ? ST_RIGHT : ST_LEFT;
    y_state = lat_d ? ST_DOWN : ST_UP;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_PREHOLD: next_state = boot ? ST_DRAW : ST_HOLD;
      ST_HOLD:    if (go) next_state = ST_CLEAR;
      ST_CLEAR: begin
        // enable may still be high from the previous pass in the first cycle
        if (enable && !first_cyc) begin
          if (x_any)      next_state = x_state;
          else if (y_any) next_state = y_state;
          else            next_state = ST_DRAW;
        end
      end
      ST_LEFT, ST_RIGHT: next_state = y_any ? y_state : ST_DRAW;
      ST_UP, ST_DOWN:    next_state = ST_DRAW;
      ST_DRAW:    if (enable && !first_cyc) next_state = ST_PREHOLD;
      default:    next_state = ST_PREHOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_PREHOLD;
      busy         <= 1'b1;
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      {lat_l, lat_r, lat_u, lat_d} <= 4'b0000;
      first_cyc    <= 1'b1;
      boot         <= 1'b1;
    end else begin
      state        <= next_state;
      busy         <= (next_state != ST_HOLD);
      first_cyc    <= (next_state != state);
      boot         <= 1'b0;
      tick_cnt     <= tick_wrap ? '0 : tick_cnt + CW'(1);
      // A wrap coinciding with consumption counts as a fresh tick.
      tick_pending <= tick_wrap | (tick_pending & ~go);
      if (go) {lat_l, lat_r, lat_u, lat_d} <= {left, right, up, down};
    end
  end

endmodule

// File: tb/tb_movement_control.sv
// Directed bench for movement_control with TICK_CYCLES=4; expectations adapt to MOVE_AUTOREPEAT_EN.
module tb_movement_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] control;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [3:0] C_PREHOLD = 4'b0100, C_HOLD = 4'b0000, C_CLEAR = 4'b0001,
                         C_LEFT = 4'b0011, C_RIGHT = 4'b0010, C_DOWN = 4'b0110,
                         C_UP = 4'b0111, C_DRAW = 4'b0101;

`ifdef MOVE_AUTOREPEAT_EN
  localparam int RPT_RIGHTS = 3;
`else
  localparam int RPT_RIGHTS = 1;
`endif

  movement_control #(.TICK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .left(left), .right(right), .up(up), .down(down),
    .enable(enable), .control(control), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered CLEAR this cycle: stay one more, then release with enable.
  task automatic leave_clear(input string tag, input logic [3:0] exp_next);
    step();
    chk({tag, "_clr2"}, 32'(control), 32'(C_CLEAR));
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk({tag, "_after_clr"}, 32'(control), 32'(exp_next));
  endtask

  // Entered DRAW this cycle: finish DRAW, PREHOLD, land in HOLD.
  task automatic finish_draw(input string tag);
    step();
    chk({tag, "_draw2"}, 32'(control), 32'(C_DRAW));
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk({tag, "_prehold"}, 32'(control), 32'(C_PREHOLD));
    step();
    chk({tag, "_hold"}, 32'(control), 32'(C_HOLD));
    chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc;

    // Reset state and boot draw sequence
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(control), 32'(C_PREHOLD));
    chk("rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b1;
    chk("boot_prehold", 32'(control), 32'(C_PREHOLD));
    for (int i = 1; i <= 17; i++) begin
      step();
      if (control !== C_DRAW) chk($sformatf("boot_draw%0d", i), 32'(control), 32'(C_DRAW));
      if (i == 17) enable = 1'b1;
    end
    chk("boot_draw_busy", 32'(busy), 32'd1);
    step();
    enable = 1'b0;
    chk("boot_prehold2", 32'(control), 32'(C_PREHOLD));
    step();
    chk("boot_hold", 32'(control), 32'(C_HOLD));
    chk("boot_hold_busy", 32'(busy), 32'd0);

    // Right only; enable in first CLEAR cycle ignored; inputs changed mid-sequence ignored
    right = 1'b1;
    step();
    chk("r_clear", 32'(control), 32'(C_CLEAR));
    chk("r_clear_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("r_first_ignored", 32'(control), 32'(C_CLEAR));
    right = 1'b0;
    left  = 1'b1;
    leave_clear("r", C_RIGHT);
    left = 1'b0;
    step();
    chk("r_draw", 32'(control), 32'(C_DRAW));
    finish_draw("r");

    // Right + down: X move then Y move
    step();
    right = 1'b1;
    down  = 1'b1;
    step();
    chk("rd_clear", 32'(control), 32'(C_CLEAR));
    leave_clear("rd", C_RIGHT);
    step();
    chk("rd_down", 32'(control), 32'(C_DOWN));
    step();
    chk("rd_draw", 32'(control), 32'(C_DRAW));
    right = 1'b0;
    down  = 1'b0;
    finish_draw("rd");

    // Up only
    step();
    up = 1'b1;
    step();
    chk("u_clear", 32'(control), 32'(C_CLEAR));
    up = 1'b0;
    leave_clear("u", C_UP);
    step();
    chk("u_draw", 32'(control), 32'(C_DRAW));
    finish_draw("u");

    // Left + right cancel: no move across several ticks
    step();
    left  = 1'b1;
    right = 1'b1;
    rc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (control !== C_HOLD) rc++;
    end
    chk("lr_cancel_nonhold", 32'(rc), 32'd0);
    left  = 1'b0;
    right = 1'b0;
    step();

    // Right held across three move windows
    right = 1'b1;
    rc = 0;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (control == C_RIGHT) rc++;
      enable = (control == C_CLEAR) || (control == C_DRAW);
    end
    enable = 1'b0;
    right  = 1'b0;
    chk("rpt_rights", 32'(rc), 32'(RPT_RIGHTS));
    chk("rpt_end_hold", 32'(control), 32'(C_HOLD));
    step();
    right = 1'b1;
    rc = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (control == C_RIGHT) rc++;
      enable = (control == C_CLEAR) || (control == C_DRAW);
    end
    enable = 1'b0;
    right  = 1'b0;
    chk("repress_rights", 32'(rc), 32'd1);
    chk("repress_hold", 32'(control), 32'(C_HOLD));

    // Reset asserted mid CLEAR acts asynchronously, then boot sequence again
    step();
    left = 1'b1;
    step();
    chk("ar_clear", 32'(control), 32'(C_CLEAR));
    left = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_async_ctrl", 32'(control), 32'(C_PREHOLD));
    chk("ar_async_busy", 32'(busy), 32'd1);
    step();
    chk("ar_held_ctrl", 32'(control), 32'(C_PREHOLD));
    reset_n = 1'b1;
    step();
    chk("ar_draw", 32'(control), 32'(C_DRAW));
    finish_draw("ar");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
